// File: rtl/rf_io_port_if.sv
// Bus bundle for rf_io_port: the core-side register file I/O signals
// and the off-core transmit/receive valid/ready handshakes.
interface rf_io_port_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] RF0DATA;
    logic             RF0WR;
    logic [WIDTH-1:0] RF1DATA;
    logic             RF1RD;
    logic             RF1VLD;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             FULL;
    logic             OVF;

    // Environment side: drives the core strobes and the off-core handshakes.
    modport master (
        output RF0DATA, RF0WR, RF1RD, OUT_READY, IN_DATA, IN_VALID,
        input  RF1DATA, RF1VLD, OUT_DATA, OUT_VALID, IN_READY, FULL, OVF
    );

    // Bridge side.
    modport slave (
        input  RF0DATA, RF0WR, RF1RD, OUT_READY, IN_DATA, IN_VALID,
        output RF1DATA, RF1VLD, OUT_DATA, OUT_VALID, IN_READY, FULL, OVF
    );
endinterface

// File: rtl/rf_io_port.sv
// rf_io_port: bridge between the core's memory-mapped I/O registers and
// off-core handshakes. RF0 writes are queued in a small transmit FIFO and
// drained over OUT_*; nibbles arriving on IN_* are held for the core as RF1.
module rf_io_port #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic           CLK,
    input logic           RST,
    rf_io_port_if.slave   bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } rx_state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [WIDTH-1:0] r_rf1_data;
    rx_state_t        r_state;
    rx_state_t        w_state_next;

    logic w_out_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_capture;

    // Flags come only from the registered count, so OUT_READY and RF0WR
    // never reach OUT_VALID/FULL combinationally.
    assign w_out_valid = (r_count != CNT_ZERO);
    assign w_full      = (r_count == CNT_FULL);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = w_out_valid && bus.OUT_READY && !RST;
    assign w_push = bus.RF0WR && (!w_full || w_pop) && !RST;
    assign w_drop = bus.RF0WR && w_full && !w_pop && !RST;

    // Storage array; contents after reset are irrelevant because count gates reads.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.RF0DATA;
        end
    end

    // Write/read pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= CNT_ZERO;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // Receive holder state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Receive holder next state; a consume cycle never also captures.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (bus.IN_VALID) begin
                    w_state_next = ST_HELD;
                    w_capture    = 1'b1;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_HELD: begin
                if (bus.RF1RD) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_HELD;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Held nibble; keeps its value after consumption until the next capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rf1_data <= {WIDTH{1'b0}};
        end else if (w_capture) begin
            r_rf1_data <= bus.IN_DATA;
        end
    end

    assign bus.OUT_DATA  = r_mem[r_rd_ptr];
    assign bus.OUT_VALID = w_out_valid;
    assign bus.FULL      = w_full;
    assign bus.OVF       = r_ovf;
    assign bus.RF1DATA   = r_rf1_data;
    assign bus.RF1VLD    = (r_state == ST_HELD);
    assign bus.IN_READY  = (r_state == ST_EMPTY) && !RST;
endmodule

// File: tb/tb_rf_io_port.sv
// Scoreboard bench for rf_io_port: directed stimulus pushes expected
// values into queues; a negedge monitor pops and compares on each
// completed OUT or RF1 handshake.
module tb_rf_io_port;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [3:0] exp_q[$];
    logic [3:0] rx_q[$];

    rf_io_port_if #(.WIDTH(4)) bus ();

    rf_io_port #(.WIDTH(4), .DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] v, input bit accept);
        bus.RF0DATA = v;
        bus.RF0WR   = 1'b1;
        if (accept) exp_q.push_back(v);
        tick();
        bus.RF0WR = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: actual=%0d entries left required=0", name, exp_q.size());
        end
    endtask

    // Monitor: compare every completed handshake against the scoreboards.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: actual=0x%0h required=no output", bus.OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(bus.OUT_DATA), 32'(e));
            end
        end
        if (!rst && bus.RF1VLD === 1'b1 && bus.RF1RD === 1'b1) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rf1_unexpected: actual=0x%0h required=no data", bus.RF1DATA);
            end else begin
                e = rx_q.pop_front();
                chk("rf1_data", 32'(bus.RF1DATA), 32'(e));
            end
        end
    end

    initial begin
        logic [3:0] fifo_vals [4];
        n_checks = 0;
        n_fail   = 0;
        fifo_vals[0] = 4'h3;
        fifo_vals[1] = 4'h5;
        fifo_vals[2] = 4'h9;
        fifo_vals[3] = 4'hC;
        rst           = 1'b1;
        bus.RF0DATA   = 4'h0;
        bus.RF0WR     = 1'b0;
        bus.RF1RD     = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.IN_DATA   = 4'h0;
        bus.IN_VALID  = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.RF0DATA   = 4'($urandom_range(15, 0));
            bus.RF0WR     = 1'($urandom_range(1, 0));
            bus.RF1RD     = 1'($urandom_range(1, 0));
            bus.OUT_READY = 1'($urandom_range(1, 0));
            bus.IN_DATA   = 4'($urandom_range(15, 0));
            bus.IN_VALID  = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk("rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
            chk("rst_full",      32'(bus.FULL),      32'h0);
            chk("rst_ovf",       32'(bus.OVF),       32'h0);
            chk("rst_rf1vld",    32'(bus.RF1VLD),    32'h0);
            chk("rst_rf1data",   32'(bus.RF1DATA),   32'h0);
            chk("rst_in_ready",  32'(bus.IN_READY),  32'h0);
        end
        #1;
        rst           = 1'b0;
        bus.RF0WR     = 1'b0;
        bus.RF1RD     = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.IN_VALID  = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.IN_READY), 32'h1);
        chk("post_rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
        tick();

        // FIFO order and pointer wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            bus.OUT_READY = 1'b0;
            for (int k = 0; k < 4; k++) push(fifo_vals[k], 1'b1);
            @(negedge clk);
            chk("fill_full",      32'(bus.FULL),      32'h1);
            chk("fill_out_valid", 32'(bus.OUT_VALID), 32'h1);
            chk("fill_head_held", 32'(bus.OUT_DATA),  32'h3);
            tick();
            bus.OUT_READY = 1'b1;
            drain("fifo_drain", 4);
            @(negedge clk);
            chk("drained_valid", 32'(bus.OUT_VALID), 32'h0);
            chk("drained_full",  32'(bus.FULL),      32'h0);
            tick();
            bus.OUT_READY = 1'b0;
        end
        chk("wrap_ovf", 32'(bus.OVF), 32'h0);

        // Overflow and full-with-pop
        for (int k = 1; k <= 4; k++) push(4'(k), 1'b1);
        @(negedge clk);
        chk("ovf_pre_full", 32'(bus.FULL), 32'h1);
        chk("ovf_pre_ovf",  32'(bus.OVF),  32'h0);
        tick();
        push(4'h7, 1'b0);
        @(negedge clk);
        chk("ovf_set",      32'(bus.OVF),      32'h1);
        chk("ovf_full",     32'(bus.FULL),     32'h1);
        chk("ovf_head",     32'(bus.OUT_DATA), 32'h1);
        tick();
        bus.OUT_READY = 1'b1;
        push(4'h8, 1'b1);
        @(negedge clk);
        chk("full_pop_full", 32'(bus.FULL), 32'h1);
        tick();
        drain("ovf_drain", 4);
        @(negedge clk);
        chk("ovf_sticky", 32'(bus.OVF), 32'h1);
        chk("ovf_empty",  32'(bus.OUT_VALID), 32'h0);
        tick();

        // Empty push with ready: visible for exactly one cycle
        bus.OUT_READY = 1'b1;
        bus.RF0DATA   = 4'hA;
        bus.RF0WR     = 1'b1;
        exp_q.push_back(4'hA);
        @(negedge clk);
        chk("ep_before", 32'(bus.OUT_VALID), 32'h0);
        tick();
        bus.RF0WR = 1'b0;
        @(negedge clk);
        chk("ep_valid", 32'(bus.OUT_VALID), 32'h1);
        chk("ep_data",  32'(bus.OUT_DATA),  32'hA);
        tick();
        @(negedge clk);
        chk("ep_gone",  32'(bus.OUT_VALID), 32'h0);
        chk("ep_queue", 32'(exp_q.size()),  32'h0);
        tick();
        bus.OUT_READY = 1'b0;

        // Receive holder
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 4'h6;
        rx_q.push_back(4'h6);
        tick();
        @(negedge clk);
        chk("rx_vld",      32'(bus.RF1VLD),   32'h1);
        chk("rx_data",     32'(bus.RF1DATA),  32'h6);
        chk("rx_in_ready", 32'(bus.IN_READY), 32'h0);
        tick();
        bus.IN_DATA = 4'hE;
        rx_q.push_back(4'hE);
        @(negedge clk);
        chk("rx_hold", 32'(bus.RF1DATA), 32'h6);
        tick();
        bus.RF1RD = 1'b1;
        tick();
        bus.RF1RD = 1'b0;
        @(negedge clk);
        chk("rx_nobypass_vld",  32'(bus.RF1VLD),   32'h0);
        chk("rx_nobypass_data", 32'(bus.RF1DATA),  32'h6);
        chk("rx_ready_again",   32'(bus.IN_READY), 32'h1);
        tick();
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        chk("rx_second_vld",  32'(bus.RF1VLD),  32'h1);
        chk("rx_second_data", 32'(bus.RF1DATA), 32'hE);
        tick();
        bus.RF1RD = 1'b1;
        tick();
        @(negedge clk);
        chk("rx_empty_rd_vld",  32'(bus.RF1VLD),   32'h0);
        chk("rx_empty_rd_data", 32'(bus.RF1DATA),  32'hE);
        chk("rx_empty_rd_rdy",  32'(bus.IN_READY), 32'h1);
        tick();
        bus.RF1RD = 1'b0;

        // Mid-operation reset
        push(4'h2, 1'b1);
        push(4'h4, 1'b1);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 4'h5;
        tick();
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        chk("mid_pre_vld",   32'(bus.RF1VLD),    32'h1);
        chk("mid_pre_valid", 32'(bus.OUT_VALID), 32'h1);
        tick();
        rst          = 1'b1;
        bus.RF1RD    = 1'b1;
        bus.RF0WR    = 1'b1;
        bus.RF0DATA  = 4'hF;
        bus.IN_VALID = 1'b1;
        exp_q.delete();
        tick();
        rst          = 1'b0;
        bus.RF1RD    = 1'b0;
        bus.RF0WR    = 1'b0;
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 32'(bus.OUT_VALID), 32'h0);
        chk("mid_full",      32'(bus.FULL),      32'h0);
        chk("mid_rf1vld",    32'(bus.RF1VLD),    32'h0);
        chk("mid_rf1data",   32'(bus.RF1DATA),   32'h0);
        chk("mid_ovf_clr",   32'(bus.OVF),       32'h0);
        chk("mid_in_ready",  32'(bus.IN_READY),  32'h1);
        tick();
        bus.OUT_READY = 1'b1;
        push(4'hB, 1'b1);
        drain("mid_drain", 2);
        bus.OUT_READY = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = 4'hD;
        rx_q.push_back(4'hD);
        tick();
        bus.IN_VALID = 1'b0;
        bus.RF1RD    = 1'b1;
        tick();
        bus.RF1RD = 1'b0;
        tick();
        chk("final_out_queue", 32'(exp_q.size()), 32'h0);
        chk("final_rx_queue",  32'(rx_q.size()),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
